// File: rtl/sfifo_arb_pkg.sv
// Shared types and sizing helpers for the sfifo write arbiter.
// The width helper never returns zero, so single-bit fields stay legal.
package sfifo_arb_pkg;

  localparam int ST_W = 1;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sfifo_rr_pick.sv
// Combinational round-robin picker: the first set request found at or after
// last+1, wrapping back to index 0.
module sfifo_rr_pick
  import sfifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last,
  output logic [GRANT_W-1:0] pick,
  output logic               any_req
);

  int   idx;
  logic found;

  always_comb begin
    pick    = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && req[GRANT_W'(idx)]) begin
        pick  = GRANT_W'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one sfifo_v2 write port among NUM_REQ
// producers, with backpressure from the FIFO full and high-threshold flags.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among valid requesters (one bubble per grant)
//   GRANT | grant_id owns the write port until last word, burst limit,
//         | high-threshold yield, or the requester goes idle
module sfifo_wr_arbiter
  import sfifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4,
  parameter int GRANT_W    = clog2_min1(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          sfifo_full,
  input  logic                          sfifo_high_th,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          grant_active,
  output logic [GRANT_W-1:0]            grant_id
);

  localparam int                 CNT_W    = clog2_min1(BURST_MAX + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BURST_MAX - 1);

  arb_state_t           state, state_nxt;
  logic [GRANT_W-1:0]   grant_id_nxt;
  logic [GRANT_W-1:0]   last_grant, last_grant_nxt;
  logic [GRANT_W-1:0]   pick;
  logic [CNT_W-1:0]     burst_cnt, burst_cnt_nxt;
  logic                 any_req;
  logic                 cur_valid;
  logic                 cur_last;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  sfifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_pick (
    .req     (req_valid),
    .last    (last_grant),
    .pick    (pick),
    .any_req (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GRANT_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_id_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_id_nxt   = grant_id;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    req_ready      = '0;
    fifo_wr        = 1'b0;
    fifo_data_in   = '0;
    grant_active   = 1'b0;
    cur_valid      = req_valid[grant_id];
    cur_last       = req_last[grant_id];
    case (state)
      IDLE: begin
        if (any_req && !sfifo_full) begin
          state_nxt      = GRANT;
          grant_id_nxt   = pick;
          last_grant_nxt = pick;
          burst_cnt_nxt  = '0;
        end
      end
      GRANT: begin
        grant_active        = 1'b1;
        req_ready[grant_id] = !sfifo_full;
        fifo_wr             = cur_valid && !sfifo_full;
        if (fifo_wr) begin
          fifo_data_in  = data_arr[grant_id];
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
        end
        // A full FIFO with a valid owner holds the grant without writing.
        if (!cur_valid ||
            (fifo_wr && (cur_last || burst_cnt == CNT_LAST || sfifo_high_th))) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// Bench for sfifo_wr_arbiter: producer word queues feed a transaction-level
// owner/pointer model; directed scenarios followed by a randomized soak.
module tb_sfifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            sfifo_full, sfifo_high_th;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_data_in;
  logic            grant_active;
  logic [GW-1:0]   grant_id;

  always #5 clk = ~clk;

  sfifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .BURST_MAX  (BM),
    .GRANT_W    (GW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .sfifo_full    (sfifo_full),
    .sfifo_high_th (sfifo_high_th),
    .fifo_wr       (fifo_wr),
    .fifo_data_in  (fifo_data_in),
    .grant_active  (grant_active),
    .grant_id      (grant_id)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Producer side: each entry is {last, data}.
  logic [DW:0] q [N][$];
  int          seq [N];
  bit [N-1:0]  stream_mask = '0;
  int          last_wid;

  // Model: owner of the write port (-1 = none), round-robin pointer, words in burst.
  int m_owner = -1;
  int m_gid   = 0;
  int m_last  = N - 1;
  int m_words = 0;

  task automatic push_word(input int i, input bit lst);
    q[i].push_back({lst, DW'((i << 5) | (seq[i] & 31))});
    seq[i]++;
  endtask

  task automatic cycle(input bit rst_in, input bit full_in, input bit hth_in, input bit [N-1:0] gate);
    bit [N-1:0]    v;
    logic [DW-1:0] d [N];
    bit [N-1:0]    l;
    bit            e_wr;
    logic [DW-1:0] e_data;
    logic [N-1:0]  e_rdy;
    int            pick;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (stream_mask[i] && q[i].size() == 0) push_word(i, 1'b0);
    for (int i = 0; i < N; i++) begin
      v[i] = gate[i] && (q[i].size() > 0);
      d[i] = (q[i].size() > 0) ? q[i][0][DW-1:0] : '0;
      l[i] = (q[i].size() > 0) ? q[i][0][DW] : 1'b0;
      req_data[i*DW +: DW] = d[i];
    end
    rst           = rst_in;
    req_valid     = v;
    req_last      = l;
    sfifo_full    = full_in;
    sfifo_high_th = hth_in;
    #1;
    e_rdy  = '0;
    e_wr   = 1'b0;
    e_data = '0;
    if (m_owner >= 0) begin
      e_rdy[m_owner] = !full_in;
      e_wr           = v[m_owner] && !full_in;
      if (e_wr) e_data = d[m_owner];
    end
    chk("grant_active", grant_active, m_owner >= 0);
    chk("grant_id", grant_id, m_gid);
    chk("req_ready", req_ready, e_rdy);
    chk("fifo_wr", fifo_wr, e_wr);
    chk("fifo_data_in", fifo_data_in, e_data);
    chk("no_overflow", fifo_wr & sfifo_full, 0);
    chk("ready_onehot", $countones(req_ready) <= 1, 1);
    last_wid = fifo_wr ? int'(grant_id) : -1;
    @(posedge clk);
    if (e_wr) void'(q[m_owner].pop_front());
    if (rst_in) begin
      m_owner = -1; m_gid = 0; m_last = N - 1; m_words = 0;
    end else if (m_owner < 0) begin
      if (v != 0 && !full_in) begin
        pick = -1;
        for (int k = 1; k <= N; k++)
          if (pick < 0 && v[(m_last + k) % N]) pick = (m_last + k) % N;
        m_owner = pick; m_gid = pick; m_last = pick; m_words = 0;
      end
    end else begin
      if (e_wr) m_words++;
      if ((e_wr && (l[m_owner] || m_words == BM || hth_in)) || !v[m_owner])
        m_owner = -1;
    end
  endtask

  task automatic drain();
    stream_mask = '0;
    repeat (14) cycle(1'b0, 1'b0, 1'b0, '1);
  endtask

  initial begin
    bit [N-1:0] gate;
    int         n, lp;
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    sfifo_full = 1'b0; sfifo_high_th = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 0;

    // Reset, then quiet inputs.
    repeat (2) cycle(1'b1, 1'b0, 1'b0, '1);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, '1);

    // Two continuous streams: bursts of BM separated by one bubble.
    stream_mask = 4'b0101;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, 1'b0, 1'b0, '1);
      chk("p2_writer", last_wid, (c % 5 == 0) ? -1 : (((c / 5) % 2 == 0) ? 0 : 2));
    end
    drain();

    // Last flag on the 2nd of 3 words splits them into two grants.
    push_word(1, 1'b0); push_word(1, 1'b1); push_word(1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, 1'b0, 1'b0, '1);
      chk("p3_writer", last_wid, (c == 1 || c == 2 || c == 4) ? 1 : -1);
    end

    // FIFO full mid-burst: grant held, no writes.
    stream_mask = 4'b1000;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '1);
    repeat (5) begin
      cycle(1'b0, 1'b1, 1'b0, '1);
      chk("p4_hold", grant_active, 1);
      chk("p4_ready", req_ready, 0);
    end
    repeat (10) cycle(1'b0, 1'b0, 1'b0, '1);
    drain();

    // High threshold: single-word grants in rotation 0,1,2,3,0.
    stream_mask = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b0, 1'b1, '1);
      chk("p5_writer", last_wid, (c % 2 == 0) ? -1 : (c / 2) % 4);
    end
    drain();

    // Reset during requester 2's 2nd word.
    stream_mask = 4'b0100;
    cycle(1'b0, 1'b0, 1'b0, '1);
    cycle(1'b0, 1'b0, 1'b0, '1);
    chk("p6_first_word", last_wid, 2);
    cycle(1'b1, 1'b0, 1'b0, '1);
    stream_mask = 4'b0101;
    cycle(1'b0, 1'b0, 1'b0, '1);
    chk("p6_idle_wr", fifo_wr, 0);
    chk("p6_idle_grant", grant_active, 0);
    cycle(1'b0, 1'b0, 1'b0, '1);
    chk("p6_ptr_reset", last_wid, 0);
    drain();

    // Randomized soak.
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) stream_mask = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        if (!stream_mask[i] && q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          n  = $urandom_range(1, 6);
          lp = $urandom_range(0, n);
          for (int w = 0; w < n; w++) push_word(i, w == lp);
        end
        gate[i] = ($urandom_range(0, 99) < 85);
      end
      cycle($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 15, gate);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
